// File: rtl/sonic_echo_responder.sv
// sonic_echo_responder: sensor-side model of the ultrasonic trigger/echo
// handshake. Accepts a trigger pulse, waits out the acoustic burst, then
// drives echo high for a width proportional to dist_cm.
// Optional feature macro: SONIC_ECHO_TIMEOUT_EN (no-target echo of
// TIMEOUT_US instead of no echo at all).
module sonic_echo_responder #(
    parameter int unsigned US_DIV      = 100,
    parameter int unsigned TRIG_MIN_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned CM_US       = 58,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLD_US     = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    output logic       echo,
    output logic       busy,
    output logic       short_trig,
    output logic       meas_done
);

    localparam int unsigned PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(US_DIV - 1);
    localparam logic [31:0] TRIG_CYC  = 32'(TRIG_MIN_US * US_DIV);
    localparam logic [31:0] BURST_CYC = 32'(BURST_US * US_DIV);
    localparam logic [31:0] HOLD_CYC  = 32'(HOLD_US * US_DIV);
    localparam logic [31:0] TO_CYC    = 32'(TIMEOUT_US * US_DIV);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_BURST, S_ECHO, S_HOLD} state_t;

    state_t        state_q;
    logic          trig_meta_q, trig_s_q, trig_prev_q;
    logic          rise_q, fall_q;
    logic [PW-1:0] pre_q;
    logic [15:0]   us_q;
    logic [8:0]    d_lat_q;
    logic [31:0]   tgt_q;
    logic          echo_q, busy_q, short_q, done_q;

    logic [31:0]   elapsed_d;
    logic [31:0]   tgt_d;
    logic          dist_ok_d;

    // Cycles spent in the current state including this one, plus the echo
    // width target derived from the latched distance.
    always_comb begin
        elapsed_d = 32'(us_q) * 32'(US_DIV) + 32'(pre_q) + 32'd1;
        tgt_d     = 32'(d_lat_q) * 32'(CM_US) * 32'(US_DIV);
        dist_ok_d = (d_lat_q != 9'd0) && (32'(d_lat_q) <= 32'(MAX_CM));
    end

    // Two-flop synchronizer for trig (trig_s) and registered edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_meta_q <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            trig_meta_q <= trig;
            trig_s_q    <= trig_meta_q;
            trig_prev_q <= trig_s_q;
            rise_q      <= trig_s_q & ~trig_prev_q;
            fall_q      <= ~trig_s_q & trig_prev_q;
        end
    end

    // Handshake FSM with µs timebase; every transition clears the timebase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            us_q    <= '0;
            d_lat_q <= '0;
            tgt_q   <= '0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            short_q <= 1'b0;
            done_q  <= 1'b0;
            // Free-running timebase; µs count saturates so a stuck trigger
            // can never wrap back into a "short" width.
            if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                if (us_q != 16'hFFFF) us_q <= us_q + 16'd1;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    // Only a fresh edge arms; a level left high is ignored.
                    if (rise_q) begin
                        state_q <= S_ARM;
                        busy_q  <= 1'b1;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                S_ARM: begin
                    if (fall_q) begin
                        pre_q <= '0;
                        us_q  <= '0;
                        if (elapsed_d >= TRIG_CYC) begin
                            state_q <= S_BURST;
                            d_lat_q <= dist_cm;
                        end else begin
                            state_q <= S_IDLE;
                            short_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_BURST: begin
                    if (elapsed_d == BURST_CYC) begin
                        pre_q <= '0;
                        us_q  <= '0;
                        if (dist_ok_d) begin
                            tgt_q   <= tgt_d;
                            echo_q  <= 1'b1;
                            state_q <= S_ECHO;
                        end else begin
                            tgt_q   <= TO_CYC;
`ifdef SONIC_ECHO_TIMEOUT_EN
                            echo_q  <= 1'b1;
                            state_q <= S_ECHO;
`else
                            state_q <= S_HOLD;
`endif
                        end
                    end
                end
                S_ECHO: begin
                    if (elapsed_d == tgt_q) begin
                        echo_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_HOLD;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                S_HOLD: begin
                    if (elapsed_d == HOLD_CYC) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    echo_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign echo       = echo_q;
    assign busy       = busy_q;
    assign short_trig = short_q;
    assign meas_done  = done_q;

endmodule
